shader_warp_scheduler: RTL and testbench

Sequences multiple warp instruction streams onto the single shared shader processor core. Each warp presents one instruction at a time through a valid/ready port; the scheduler grants one warp at a time and forwards its instruction to the core. It holds the core until the core signals writeback completion, and enforces round-robin fairness with a per-warp issue quantum. It sits between the per-warp instruction buffers and the shader processor instruction port.

---
 rtl/shader_sched_pkg.sv | 12 +
 rtl/shader_warp_scheduler_rr_arbiter.sv | 28 ++
 rtl/shader_warp_scheduler.sv | 127 ++++++++++++
 tb/tb_shader_warp_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shader_sched_pkg.sv
// Shared types and constants for the shader warp scheduler.
package shader_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    localparam int unsigned SCHED_INSTR_W = 32;

endpackage

// File: rtl/shader_warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from last_grant+1.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_grant
);

    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest hit overwrites; i == NUM_REQ wraps to last_grant.
    always_comb begin
        grant     = last_grant;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            idx = last_grant + IDX_W'(i);
            if (req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shader_warp_scheduler.sv
// Warp scheduler: round-robin with issue quantum onto one shader core.
// Optional priority override port enabled by defining SHADER_SCHED_PRIO_EN.
module shader_warp_scheduler
    import shader_sched_pkg::*;
#(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned QUANTUM   = 8,
    parameter int unsigned WARP_ID_W = $clog2(NUM_WARPS)
) (
`ifdef SHADER_SCHED_PRIO_EN
    input  logic                               prio_valid,
    input  logic [WARP_ID_W-1:0]               prio_warp,
`endif
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_WARPS-1:0]               warp_valid,
    input  logic [NUM_WARPS*SCHED_INSTR_W-1:0] warp_instr,
    output logic [NUM_WARPS-1:0]               warp_ready,
    input  logic [NUM_WARPS-1:0]               warp_enable,
    output logic                               core_instr_valid,
    output logic [SCHED_INSTR_W-1:0]           core_instr,
    input  logic                               core_instr_ready,
    input  logic                               core_done,
    output logic [WARP_ID_W-1:0]               cur_warp,
    output logic                               busy,
    output logic [31:0]                        issue_cnt
);

    localparam int unsigned QCNT_W = $clog2(QUANTUM + 1);

    sched_state_t         state_q, state_d;
    logic [WARP_ID_W-1:0] sel_q, sel_d;
    logic [WARP_ID_W-1:0] last_grant_q, last_grant_d;
    logic [QCNT_W-1:0]    qcnt_q, qcnt_d;
    logic [31:0]          issue_cnt_q, issue_cnt_d;

    logic [NUM_WARPS-1:0] eligible;
    logic [WARP_ID_W-1:0] rr_grant, pick;
    logic                 rr_any, pick_any;

    assign eligible = warp_valid & warp_enable;

    rr_arbiter #(
        .NUM_REQ (NUM_WARPS),
        .IDX_W   (WARP_ID_W)
    ) u_rr_arbiter (
        .req        (eligible),
        .last_grant (last_grant_q),
        .grant      (rr_grant),
        .any_grant  (rr_any)
    );

`ifdef SHADER_SCHED_PRIO_EN
    logic prio_hit;
    assign prio_hit = prio_valid && eligible[prio_warp];
    assign pick     = prio_hit ? prio_warp : rr_grant;
    assign pick_any = prio_hit || rr_any;
`else
    assign pick     = rr_grant;
    assign pick_any = rr_any;
`endif

    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        last_grant_d     = last_grant_q;
        qcnt_d           = qcnt_q;
        issue_cnt_d      = issue_cnt_q;
        core_instr_valid = 1'b0;
        core_instr       = '0;
        warp_ready       = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d        = pick;
                    last_grant_d = pick;
                    qcnt_d       = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                core_instr_valid  = 1'b1;
                core_instr        = warp_instr[SCHED_INSTR_W*int'(sel_q) +: SCHED_INSTR_W];
                warp_ready[sel_q] = core_instr_ready;
                // A warp withdrawing its request mid-issue is treated as a protocol abort.
                if (!warp_valid[sel_q]) begin
                    state_d = IDLE;
                end else if (core_instr_ready) begin
                    if (qcnt_q != QCNT_W'(QUANTUM)) qcnt_d = qcnt_q + 1'b1;
                    issue_cnt_d = issue_cnt_q + 32'd1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    if (qcnt_q < QCNT_W'(QUANTUM) && warp_valid[sel_q] && warp_enable[sel_q]) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= WARP_ID_W'(NUM_WARPS - 1);
            qcnt_q       <= '0;
            issue_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            qcnt_q       <= qcnt_d;
            issue_cnt_q  <= issue_cnt_d;
        end
    end

    assign cur_warp  = sel_q;
    assign busy      = (state_q != IDLE);
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_shader_warp_scheduler.sv
// Self-checking bench for shader_warp_scheduler (NUM_WARPS=4, QUANTUM=2) with a transaction-level model.
module tb_shader_warp_scheduler;

    localparam int NW = 4;
    localparam int Q  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NW-1:0]   warp_valid = '0;
    logic [NW-1:0]   warp_enable = '0;
    logic [NW*32-1:0] warp_instr = '0;
    logic [NW-1:0]   warp_ready;
    logic            core_instr_valid;
    logic [31:0]     core_instr;
    logic            core_instr_ready = 1'b0;
    logic            core_done = 1'b0;
    logic [1:0]      cur_warp;
    logic            busy;
    logic [31:0]     issue_cnt;
`ifdef SHADER_SCHED_PRIO_EN
    logic            prio_valid = 1'b0;
    logic [1:0]      prio_warp = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: last granted warp, current warp, instructions issued in the current burst.
    int m_last = NW - 1;
    int m_cur = 0;
    int m_burst = 0;
    int m_issued = 0;
    bit m_have = 1'b0;
    bit keep_instr = 1'b0;

    always #5 clk = ~clk;

    shader_warp_scheduler #(
        .NUM_WARPS (NW),
        .QUANTUM   (Q)
    ) dut (
`ifdef SHADER_SCHED_PRIO_EN
        .prio_valid       (prio_valid),
        .prio_warp        (prio_warp),
`endif
        .clk              (clk),
        .rst_n            (rst_n),
        .warp_valid       (warp_valid),
        .warp_instr       (warp_instr),
        .warp_ready       (warp_ready),
        .warp_enable      (warp_enable),
        .core_instr_valid (core_instr_valid),
        .core_instr       (core_instr),
        .core_instr_ready (core_instr_ready),
        .core_done        (core_done),
        .cur_warp         (cur_warp),
        .busy             (busy),
        .issue_cnt        (issue_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_instr;
        for (int k = 0; k < NW; k++) begin
            if (!(keep_instr && k == 2)) warp_instr[32*k +: 32] = $urandom;
        end
    endtask

    // Next warp to issue: continue burst if allowed, else first eligible after last grant.
    task automatic predict(output int w, output int lat);
        logic [NW-1:0] elig;
        elig = warp_valid & warp_enable;
        if (m_have && m_burst < Q && elig[m_cur]) begin
            w   = m_cur;
            lat = 0;
        end else begin
            w   = -1;
            lat = 1;
            for (int k = 1; k <= NW; k++) begin
                if (w < 0 && elig[(m_last + k) % NW]) w = (m_last + k) % NW;
            end
            m_cur   = w;
            m_last  = w;
            m_burst = 0;
        end
    endtask

    task automatic serve_one(input int stall, input int done_lat, input bit end_seg,
                             output int got);
        int w, lat_exp, lat;
        logic [31:0] held;
        predict(w, lat_exp);
        lat = 0;
        while (!core_instr_valid && lat < 20) begin
            tick;
            lat++;
        end
        check("issue_latency", lat, lat_exp);
        got = int'(cur_warp);
        check("cur_warp", {30'd0, cur_warp}, w);
        check("core_instr", core_instr, warp_instr[32*w +: 32]);
        check("busy_issue", {31'd0, busy}, 1);
        held = core_instr;
        for (int s = 0; s < stall; s++) begin
            check("stall_ready", {28'd0, warp_ready}, 0);
            tick;
            check("stall_valid", {31'd0, core_instr_valid}, 1);
            check("stall_instr", core_instr, held);
        end
        core_instr_ready = 1'b1;
        #1;
        check("warp_ready", {28'd0, warp_ready}, 32'd1 << w);
        tick;
        core_instr_ready = 1'b0;
        m_burst++;
        m_issued++;
        m_have = 1'b1;
        check("issue_cnt", issue_cnt, m_issued);
        check("wait_valid", {31'd0, core_instr_valid}, 0);
        if (end_seg) begin
            warp_valid = '0;
            m_have = 1'b0;
        end else begin
            rand_instr();
        end
        for (int d = 0; d < done_lat; d++) begin
            tick;
            check("wait_instr_zero", core_instr, 0);
        end
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
    endtask

    initial begin
        int got;
        int order_exp[9];
        logic [NW-1:0] vm, em;
        order_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        // Reset and idle behaviour.
        #2 rst_n = 1'b0;
        tick;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_valid", {31'd0, core_instr_valid}, 0);
        check("rst_instr", core_instr, 0);
        check("rst_ready", {28'd0, warp_ready}, 0);
        check("rst_cur_warp", {30'd0, cur_warp}, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        rst_n = 1'b1;
        core_instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_done = (i == 1);
            tick;
            check("idle_busy", {31'd0, busy}, 0);
            check("idle_valid", {31'd0, core_instr_valid}, 0);
            check("idle_issue_cnt", issue_cnt, 0);
        end
        core_done = 1'b0;
        core_instr_ready = 1'b0;

        // All warps valid: grant order follows quantum of 2.
        warp_valid = '1;
        warp_enable = '1;
        rand_instr();
        for (int i = 0; i < 9; i++) begin
            serve_one(0, 2, i == 8, got);
            check("rr_order", got, order_exp[i]);
            if (i == 7) check("issue_cnt_8", issue_cnt, 8);
        end

        // Sole warp 2 re-granted after quantum; long ready stall included.
        keep_instr = 1'b1;
        warp_instr[64 +: 32] = 32'h0050_0093;
        warp_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            serve_one((i == 1) ? 5 : 0, 1, i == 4, got);
            check("sole_warp", got, 2);
        end
        keep_instr = 1'b0;

        // Enable mask 1010: only warps 1 and 3 granted.
        warp_valid = '1;
        warp_enable = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            serve_one(i % 2, 0, i == 5, got);
            check("masked_grant", {31'd0, got == 1 || got == 3}, 1);
        end

        // Random segments against the model.
        for (int seg = 0; seg < 10; seg++) begin
            int n;
            do begin
                vm = NW'($urandom_range(1, 15));
                em = NW'($urandom_range(1, 15));
            end while ((vm & em) == '0);
            warp_valid = vm;
            warp_enable = em;
            rand_instr();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                serve_one($urandom_range(0, 3), $urandom_range(0, 3), i == n - 1, got);
            end
        end

        // Reset asserted during WAIT.
        warp_valid = '1;
        warp_enable = '1;
        tick;
        core_instr_ready = 1'b1;
        tick;
        core_instr_ready = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        tick;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_cur_warp", {30'd0, cur_warp}, 0);
        check("midrst_issue_cnt", issue_cnt, 0);
        warp_valid = '0;
        rst_n = 1'b1;
        tick;
        m_last = NW - 1;
        m_have = 1'b0;
        m_issued = 0;

`ifdef SHADER_SCHED_PRIO_EN
        // Grant warp 0 so round-robin points at 1, then prioritise warp 3.
        warp_valid = '1;
        serve_one(0, 0, 1'b1, got);
        prio_valid = 1'b1;
        prio_warp = 2'd3;
        warp_valid = '1;
        tick;
        check("prio_grant", {30'd0, cur_warp}, 3);
        check("prio_valid_out", {31'd0, core_instr_valid}, 1);
        prio_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
